// File: rtl/sdram_cmd_sched_if.sv
// Request/acknowledge and command-strobe bundle between the requesters and
// the SDRAM command scheduler.
interface sdram_cmd_sched_if;
  logic host_req;
  logic host_wr;
  logic ref_req;
  logic mode_req;
  logic cmd_act;
  logic cmd_rd;
  logic cmd_wr;
  logic cmd_pre;
  logic cmd_ref;
  logic cmd_lmr;
  logic cmack;
  logic ref_ack;
  logic mode_ack;
  logic busy;

  modport master (
    output host_req, host_wr, ref_req, mode_req,
    input  cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr,
    input  cmack, ref_ack, mode_ack, busy
  );

  modport slave (
    input  host_req, host_wr, ref_req, mode_req,
    output cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr,
    output cmack, ref_ack, mode_ack, busy
  );
endinterface

// File: rtl/sdram_cmd_sched.sv
// SDRAM command scheduler: fixed-priority arbitration of refresh, load-mode
// and host requests, sequenced into one-cycle strobes with timing waits.
module sdram_cmd_sched #(
  parameter int RCD_CYC = 3,
  parameter int RP_CYC  = 3,
  parameter int RFC_CYC = 7,
  parameter int MRD_CYC = 2,
  parameter int CNT_W   = 4
) (
  input logic             clk0,
  input logic             reset,
  sdram_cmd_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ACT_WAIT,
    PRE_WAIT,
    REF_PRE,
    REF_WAIT,
    LMR_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(RCD_CYC - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(RP_CYC - 1);
  localparam logic [CNT_W-1:0] RFC_LD = CNT_W'(RFC_CYC - 1);
  localparam logic [CNT_W-1:0] MRD_LD = CNT_W'(MRD_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_lat;
  logic             cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr;
  logic             cmack, ref_ack, mode_ack, busy;

  // Strobes and acks default low so each is a single-cycle pulse; the wait
  // counter is reloaded on every state entry and exits when it reaches zero.
  always_ff @(posedge clk0) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_lat   <= 1'b0;
      cmd_act  <= 1'b0;
      cmd_rd   <= 1'b0;
      cmd_wr   <= 1'b0;
      cmd_pre  <= 1'b0;
      cmd_ref  <= 1'b0;
      cmd_lmr  <= 1'b0;
      cmack    <= 1'b0;
      ref_ack  <= 1'b0;
      mode_ack <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cmd_act  <= 1'b0;
      cmd_rd   <= 1'b0;
      cmd_wr   <= 1'b0;
      cmd_pre  <= 1'b0;
      cmd_ref  <= 1'b0;
      cmd_lmr  <= 1'b0;
      cmack    <= 1'b0;
      ref_ack  <= 1'b0;
      mode_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ref_req) begin
            cmd_pre <= 1'b1;
            cnt     <= RP_LD;
            state   <= REF_PRE;
            busy    <= 1'b1;
          end else if (bus.mode_req) begin
            cmd_lmr  <= 1'b1;
            mode_ack <= 1'b1;
            cnt      <= MRD_LD;
            state    <= LMR_WAIT;
            busy     <= 1'b1;
          end else if (bus.host_req) begin
            cmd_act <= 1'b1;
            wr_lat  <= bus.host_wr;
            cnt     <= RCD_LD;
            state   <= ACT_WAIT;
            busy    <= 1'b1;
          end
        end
        ACT_WAIT: begin
          if (cnt == '0) begin
            cmd_wr <= wr_lat;
            cmd_rd <= !wr_lat;
            cmack  <= 1'b1;
            cnt    <= RP_LD;
            state  <= PRE_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        REF_PRE: begin
          if (cnt == '0) begin
            cmd_ref <= 1'b1;
            ref_ack <= 1'b1;
            cnt     <= RFC_LD;
            state   <= REF_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PRE_WAIT, REF_WAIT, LMR_WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_act  = cmd_act;
  assign bus.cmd_rd   = cmd_rd;
  assign bus.cmd_wr   = cmd_wr;
  assign bus.cmd_pre  = cmd_pre;
  assign bus.cmd_ref  = cmd_ref;
  assign bus.cmd_lmr  = cmd_lmr;
  assign bus.cmack    = cmack;
  assign bus.ref_ack  = ref_ack;
  assign bus.mode_ack = mode_ack;
  assign bus.busy     = busy;

endmodule

// File: doc/sdram_cmd_sched.md
Name: sdram_cmd_sched

Overview:
- Command scheduler for the SDRAM controller. Arbitrates between three requesters: host read/write, auto-refresh, and load-mode.
- Sequences each request into one-cycle SDRAM command strobes and enforces tRCD, tRP, tRFC and tMRD with a shared down-counter.
- Returns a one-cycle acknowledge to the winning requester.
- Sits between the host command decoder / refresh counter and the SDRAM command/address output stage.

Parameters:
RCD_CYC, 3, cycles from ACTIVE to READ/WRITE (min 2)
RP_CYC, 3, cycles from PRECHARGE or auto-precharge READ/WRITE to next command (min 2)
RFC_CYC, 7, cycles from AUTO REFRESH to next command (min 2)
MRD_CYC, 2, cycles from LOAD MODE to next command (min 2)
CNT_W, 4, timing counter width; must hold max(param)-1

Ports:
clk0 input 1 system clock, all logic on rising edge
reset input 1 synchronous active-high reset
host_req input 1 host read/write request; level, held until cmack
host_wr input 1 1=write, 0=read; stable while host_req high
ref_req input 1 refresh request; level, held until ref_ack
mode_req input 1 load-mode request; level, held until mode_ack
cmd_act output 1 ACTIVE strobe
cmd_rd output 1 READ with auto-precharge strobe
cmd_wr output 1 WRITE with auto-precharge strobe
cmd_pre output 1 PRECHARGE-ALL strobe
cmd_ref output 1 AUTO REFRESH strobe
cmd_lmr output 1 LOAD MODE REGISTER strobe
cmack output 1 host acknowledge pulse
ref_ack output 1 refresh acknowledge pulse
mode_ack output 1 load-mode acknowledge pulse
busy output 1 high whenever state != IDLE

Behaviour:
- Reset (sync, reset=1 at rising clk0):
  - state=IDLE, counter=0.
  - All strobes, acks and busy are 0 the following cycle.
  - Reset mid-sequence aborts with no further strobes.
  - Requests still asserted are re-arbitrated from IDLE after reset deasserts.
- All outputs are registered. Every strobe and ack is exactly one cycle wide, and at most one cmd_* is high in any cycle.
- Requests are sampled only in IDLE. Fixed priority: ref_req > mode_req > host_req. A losing request stays pending and is not lost.
- States: IDLE, ACT_WAIT, PRE_WAIT, REF_PRE, REF_WAIT, LMR_WAIT.
- Wait counter: loaded with param-1 on state entry and decremented each cycle. The state exits in the cycle in which the counter is 0, so each wait state lasts exactly param cycles.
- IDLE:
  - ref_req -> pulse cmd_pre, go REF_PRE (RP_CYC).
  - else mode_req -> pulse cmd_lmr and mode_ack, go LMR_WAIT (MRD_CYC).
  - else host_req -> pulse cmd_act, latch host_wr, go ACT_WAIT (RCD_CYC).
  - else stay in IDLE.
- ACT_WAIT exit: pulse cmd_wr if latched wr=1, else cmd_rd. Pulse cmack in the same cycle. Go PRE_WAIT (RP_CYC).
- REF_PRE exit: pulse cmd_ref and ref_ack together, go REF_WAIT (RFC_CYC).
- PRE_WAIT, REF_WAIT, LMR_WAIT exit: go IDLE.
- Ack timing: each ack coincides with the strobe that commits the request. This guarantees a registered requester drops its request before IDLE samples again (all waits >= 2).
- Back-to-back: a request held high, or newly raised, when IDLE is reached is accepted in that IDLE cycle. Its first strobe appears the next cycle, so there is a minimum 1 IDLE cycle between sequences.
- host_wr changes after acceptance are ignored.
- Requests arriving while busy are not acknowledged until their sequence commits.

Test Plan:
- Host read, defaults:
  - Stimulus: host_req=1, host_wr=0 in cycle 0, dropped after cmack.
  - Required: cmd_act cycle 1; cmd_rd and cmack cycle 4; busy=1 cycles 1-6; IDLE cycle 7; no other strobes.
- Back-to-back writes:
  - Stimulus: host_req held through two acks, host_wr=1.
  - Required: cmd_act at 1 and 8; cmd_wr and cmack at 4 and 11.
- Refresh vs host collision:
  - Stimulus: ref_req=1 and host_req=1 in cycle 0.
  - Required: cmd_pre 1; cmd_ref and ref_ack 4; IDLE 11; host cmd_act 12; cmd_rd 15.
- Load mode:
  - Stimulus: mode_req=1 in cycle 0.
  - Required: cmd_lmr and mode_ack cycle 1; busy cycles 1-2; IDLE cycle 3. Same stimulus with ref_req also high: refresh first, cmd_lmr in cycle 12.
- Reset mid-sequence:
  - Stimulus: assert reset in cycle 2 of a host read.
  - Required: all outputs 0 from cycle 3; no cmd_rd. With host_req still high after reset release, a fresh cmd_act occurs 1 cycle after the first IDLE cycle.
- Parameter sweep:
  - Stimulus: RCD_CYC=2, RP_CYC=2, RFC_CYC=2, MRD_CYC=2.
  - Required: cmd_act to cmd_rd = 2 cycles; cmd_pre to cmd_ref = 2; cmd_ref to next IDLE = 2; strobes stay one-hot and one cycle wide throughout.
